// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the async FIFO and its read-side stages
package fifo_pkg;

  localparam int FIFO_WIDTH   = 32;
  localparam int FIFO_RATIO   = 4;
  localparam int FIFO_TIMEOUT = 16;
  localparam int FIFO_CNT_W   = $clog2(FIFO_RATIO + 1);

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Low n bits set; callers truncate to their word count.
  function automatic logic [63:0] keep_mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO pop port and packed-beat stream of the read-side packer
interface fifo_rd_packer_if #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
);
  logic                     fifo_empty;
  logic                     fifo_rd_en;
  logic [WIDTH-1:0]         fifo_rd_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*RATIO-1:0]   out_data;
  logic [RATIO-1:0]         out_keep;
  logic                     out_last;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fifo_rd_tmo.sv
// rtl/fifo_rd_tmo.sv - saturating idle counter that flags when TIMEOUT idle cycles have elapsed
module fifo_rd_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);
  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [TW-1:0] tmo;

  // Saturating at the hit value keeps hit asserted while the partial beat waits for space.
  always_ff @(posedge clk) begin
    if (rst || clr || !inc) begin
      tmo <= '0;
    end else if (tmo != TMAX) begin
      tmo <= tmo + 1'b1;
    end
  end

  assign hit = (TIMEOUT != 0) && (tmo == TMAX);
endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs RATIO of them into one wide beat
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int RATIO   = FIFO_RATIO,
  parameter int TIMEOUT = FIFO_TIMEOUT
) (
  input  logic              rd_clk,
  input  logic              rrst,
  fifo_rd_packer_if.master  bus
);
  localparam int            CW      = cnt_width(RATIO);
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

  logic [WIDTH-1:0]       pack [RATIO];
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_cap;
  logic                   pend;
  logic                   flush_req;
  logic                   tmo_hit;
  logic                   tmo_inc;
  logic                   out_free;
  logic                   load_full;
  logic                   load_part;
  logic [RATIO-1:0]       keep_part;
  logic [WIDTH*RATIO-1:0] pack_flat;
  logic [WIDTH*RATIO-1:0] part_flat;

  always_comb begin
    pack_flat = '0;
    part_flat = '0;
    cnt_cap   = cnt + CW'(pend);
    out_free  = !bus.out_valid || bus.out_ready;
    load_full = (cnt_cap == RATIO_C) && out_free;
    load_part = (flush_req || tmo_hit) && !pend && (cnt != '0) && (cnt < RATIO_C) && out_free;
    tmo_inc   = (cnt != '0) && !pend && bus.fifo_empty && !flush_req;
    keep_part = RATIO'(keep_mask(int'(cnt)));
    for (int i = 0; i < RATIO; i++) begin
      pack_flat[i*WIDTH +: WIDTH] = (pend && cnt == CW'(i)) ? bus.fifo_rd_data : pack[i];
      part_flat[i*WIDTH +: WIDTH] = keep_part[i] ? pack[i] : '0;
    end
    // A pack leaving this cycle frees slot 0, so popping continues without a bubble.
    bus.fifo_rd_en = !rrst && !bus.fifo_empty && !flush_req && !tmo_hit
                     && (load_full || (cnt_cap < RATIO_C));
  end

  always_ff @(posedge rd_clk) begin
    for (int i = 0; i < RATIO; i++) begin
      if (pend && cnt == CW'(i)) begin
        pack[i] <= bus.fifo_rd_data;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rrst) begin
      cnt           <= '0;
      pend          <= 1'b0;
      flush_req     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      pend <= bus.fifo_rd_en;
      if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (load_full) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= pack_flat;
        bus.out_keep  <= '1;
        bus.out_last  <= flush_req || bus.flush;
        cnt           <= '0;
        flush_req     <= 1'b0;
      end else if (load_part) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= part_flat;
        bus.out_keep  <= keep_part;
        bus.out_last  <= 1'b1;
        cnt           <= '0;
        flush_req     <= 1'b0;
      end else begin
        cnt <= cnt_cap;
        if (flush_req && cnt == '0 && !pend) begin
          flush_req <= 1'b0;
        end else if (bus.flush) begin
          flush_req <= 1'b1;
        end
      end
    end
  end

  fifo_rd_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk (rd_clk),
    .rst (rrst),
    .clr (load_full || load_part),
    .inc (tmo_inc),
    .hit (tmo_hit)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed bench for the FIFO read-side packer
module tb_fifo_rd_packer;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;

  logic rd_clk = 1'b0;
  logic rrst;

  fifo_rd_packer_if #(.WIDTH(32), .RATIO(4)) bus ();

  fifo_rd_packer #(.WIDTH(32), .RATIO(4), .TIMEOUT(16)) dut (
    .rd_clk (rd_clk),
    .rrst   (rrst),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fq[$];
  beat_t       beats[$];
  logic        pop_pending = 1'b0;
  logic        prev_valid = 1'b0;
  int          cyc = 0;
  int          pops = 0;
  int          run = 0;
  int          max_run = 0;
  int          viol = 0;
  int          last_pop_cyc = 0;
  int          rise_cyc = -1;
  int          delay;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are observed on the falling edge, half a cycle away from the DUT's edge.
  always @(negedge rd_clk) begin
    cyc++;
    pop_pending = bus.fifo_rd_en;
    if (bus.fifo_rd_en) begin
      last_pop_cyc = cyc;
      if (bus.fifo_empty) viol++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bus.out_valid && bus.out_ready) beats.push_back({bus.out_data, bus.out_keep, bus.out_last});
    if (bus.out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = bus.out_valid;
  end

  // Registered-read FIFO model: a pop seen this cycle presents its word after the edge.
  task automatic step();
    @(posedge rd_clk);
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
      pops++;
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic clear();
    beats.delete();
    max_run  = 0;
    pops     = 0;
    rise_cyc = -1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [127:0] d,
                          input logic [3:0] k, input logic l);
    if (idx < beats.size()) begin
      chk({tag, "_data"}, beats[idx].data, d);
      chk({tag, "_keep"}, 128'(beats[idx].keep), 128'(k));
      chk({tag, "_last"}, 128'(beats[idx].last), 128'(l));
    end else begin
      chk({tag, "_present"}, 128'(beats.size()), 128'(idx + 1));
    end
  endtask

  initial begin
    rrst             = 1'b1;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
    repeat (3) step();
    rrst = 1'b0;
    step();
    chk("rst_valid", 128'(bus.out_valid), 0);
    chk("rst_data",  bus.out_data, 0);
    chk("rst_keep",  128'(bus.out_keep), 0);
    chk("rst_last",  128'(bus.out_last), 0);
    chk("rst_rd_en", 128'(bus.fifo_rd_en), 0);

    // Two full beats streaming with out_ready high.
    clear();
    for (int i = 1; i <= 8; i++) push(32'(i));
    repeat (14) step();
    chk("t1_beats", 128'(beats.size()), 2);
    chk_beat("t1_b0", 0, 128'h00000004_00000003_00000002_00000001, 4'hF, 1'b0);
    chk_beat("t1_b1", 1, 128'h00000008_00000007_00000006_00000005, 4'hF, 1'b0);
    chk("t1_rd_run", 128'(max_run), 8);

    // Backpressure: one beat held in the output register plus one full pack.
    clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(32'h11 + 32'(i));
    repeat (20) step();
    chk("t2_hold_pops",  128'(pops), 8);
    chk("t2_hold_rd_en", 128'(bus.fifo_rd_en), 0);
    chk("t2_hold_valid", 128'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    repeat (20) step();
    chk("t2_beats", 128'(beats.size()), 3);
    chk_beat("t2_b0", 0, 128'h00000014_00000013_00000012_00000011, 4'hF, 1'b0);
    chk_beat("t2_b1", 1, 128'h00000018_00000017_00000016_00000015, 4'hF, 1'b0);
    chk_beat("t2_b2", 2, 128'h0000001C_0000001B_0000001A_00000019, 4'hF, 1'b0);
    chk("t2_pops", 128'(pops), 12);

    // Timeout partial beat after three words.
    clear();
    push(32'hA1); push(32'hA2); push(32'hA3);
    repeat (30) step();
    delay = rise_cyc - (last_pop_cyc + 1);
    chk("t3_delay_ok", 128'(delay >= 16 && delay <= 17), 1);
    chk("t3_beats", 128'(beats.size()), 1);
    chk_beat("t3_b0", 0, 128'h00000000_000000A3_000000A2_000000A1, 4'h7, 1'b1);

    // Flush with one word captured and one in flight.
    clear();
    push(32'hB1); push(32'hB2);
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (10) step();
    chk("t4_beats", 128'(beats.size()), 1);
    chk_beat("t4_b0", 0, 128'h00000000_00000000_000000B2_000000B1, 4'h3, 1'b1);

    // Flush with nothing packed produces no beat.
    clear();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (5) step();
    chk("t4_empty_beats", 128'(beats.size()), 0);
    chk("t4_empty_valid", 128'(bus.out_valid), 0);

    // Flush in the same cycle as the completing capture.
    clear();
    push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
    repeat (4) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (8) step();
    chk("t5_beats", 128'(beats.size()), 1);
    chk_beat("t5_b0", 0, 128'h000000C4_000000C3_000000C2_000000C1, 4'hF, 1'b1);

    // Reset with a held beat and two words packed.
    clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h31 + 32'(i));
    repeat (7) step();
    chk("t6_pre_valid", 128'(bus.out_valid), 1);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    chk("t6_rst_valid", 128'(bus.out_valid), 0);
    chk("t6_rst_data",  bus.out_data, 0);
    chk("t6_rst_keep",  128'(bus.out_keep), 0);
    chk("t6_rst_last",  128'(bus.out_last), 0);
    chk("t6_rst_rd_en", 128'(bus.fifo_rd_en), 0);
    clear();
    bus.out_ready = 1'b1;
    push(32'h41); push(32'h42); push(32'h43); push(32'h44);
    repeat (12) step();
    chk("t6_beats", 128'(beats.size()), 1);
    chk_beat("t6_b0", 0, 128'h00000044_00000043_00000042_00000041, 4'hF, 1'b0);

    chk("rd_en_while_empty", 128'(viol), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
